npu_operand_mux: RTL

Registered, parametrised N-input operand selector for the NPU datapath. It extends the combinational 3:1 select with three additions: any input count, a valid/ready handshake on every channel, and a 2-entry output skid buffer whose input-side ready never depends combinationally on the output-side ready. It sits between the BRAM read ports / forwarding paths and the MAC array operand inputs. It keeps the existing select convention: select code 0 inserts zero, codes 1..NUM_IN pick a channel. It also adds a round-robin auto-select mode.

---
 rtl/npu_operand_mux.sv | 138 +++++++++++++
 1 files changed

// File: rtl/npu_operand_mux.sv
// npu_operand_mux: N-input registered operand selector feeding the MAC array.
// Select code 0 inserts a zero operand and codes 1..NUM_IN pick a channel.
// A round-robin mode is also available.
// Every channel has a valid/ready handshake. The output side is a 2-entry
// skid buffer. Input-side ready is derived from the registered fill level
// only, so out_ready never reaches in_ready combinationally.
module npu_operand_mux #(
  parameter int BIT_DEPTH = 8,
  parameter int NUM_IN    = 3,
  localparam int SEL_W    = $clog2(NUM_IN + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_IN*BIT_DEPTH-1:0] in_data,
  input  logic [NUM_IN-1:0]           in_valid,
  output logic [NUM_IN-1:0]           in_ready,
  input  logic [SEL_W-1:0]            sel,
  input  logic                        rr_en,
  output logic [BIT_DEPTH-1:0]        out_data,
  output logic [SEL_W-1:0]            out_src,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        sel_err
);

  // Buffer state: fill level plus head/tail slot pointers.
  logic [1:0]           count;
  logic                 rd_ptr;
  logic                 wr_ptr;
  logic [BIT_DEPTH-1:0] buf_data [2];
  logic [SEL_W-1:0]     buf_src  [2];

  // Round-robin search start; this is the channel that was granted last, plus one.
  logic [SEL_W-1:0]     rr_ptr;

  logic                 space;
  logic                 push;
  logic                 pop;
  logic                 found;
  logic                 sel_bad;
  logic [BIT_DEPTH-1:0] push_data;
  logic [SEL_W-1:0]     push_src;
  logic [SEL_W-1:0]     rr_next;
  logic [NUM_IN-1:0]    ready_c;

  // Space is evaluated before any pop, so a full buffer never takes a beat.
  assign space   = (count != 2'd2);
  assign pop     = (count != 2'd0) & out_ready;
  assign sel_bad = (int'(sel) > NUM_IN);

  // Grant selection: choose the beat to push and the channel that gets ready.
  always_comb begin
    push      = 1'b0;
    push_data = '0;
    push_src  = '0;
    ready_c   = '0;
    rr_next   = rr_ptr;
    found     = 1'b0;
    if (rr_en) begin
      // Offset i from rr_ptr maps to channel c when rr_ptr+i == c (mod NUM_IN).
      for (int i = 0; i < NUM_IN; i++) begin
        for (int c = 0; c < NUM_IN; c++) begin
          if (!found && in_valid[c] &&
              ((int'(rr_ptr) + i == c) || (int'(rr_ptr) + i == c + NUM_IN))) begin
            found      = 1'b1;
            ready_c[c] = space;
            push       = space;
            push_data  = in_data[c*BIT_DEPTH +: BIT_DEPTH];
            push_src   = SEL_W'(c + 1);
            rr_next    = (c == NUM_IN - 1) ? '0 : SEL_W'(c + 1);
          end
        end
      end
    end else if (sel == '0) begin
      // A zero operand is pushed whenever the buffer has room. No channel is acknowledged.
      push = space;
    end else if (!sel_bad) begin
      for (int c = 0; c < NUM_IN; c++) begin
        if (int'(sel) == c + 1) begin
          ready_c[c] = space;
          push       = in_valid[c] & space;
          push_data  = in_data[c*BIT_DEPTH +: BIT_DEPTH];
          push_src   = sel;
        end
      end
    end
  end

  // in_ready is held low while rst is asserted. Otherwise it follows the grant.
  assign in_ready = rst ? '0 : ready_c;

  // Skid buffer: the write goes to the tail slot, so the head stays stable under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count       <= 2'd0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      buf_data[0] <= '0;
      buf_data[1] <= '0;
      buf_src[0]  <= '0;
      buf_src[1]  <= '0;
    end else begin
      if (push) begin
        buf_data[wr_ptr] <= push_data;
        buf_src[wr_ptr]  <= push_src;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Arbitration state and the sticky select-error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr  <= '0;
      sel_err <= 1'b0;
    end else begin
      if (rr_en && push) begin
        rr_ptr <= rr_next;
      end
      if (!rr_en && sel_bad) begin
        sel_err <= 1'b1;
      end
    end
  end

  assign out_valid = (count != 2'd0);
  assign out_data  = buf_data[rd_ptr];
  assign out_src   = buf_src[rd_ptr];

endmodule
